// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and helpers for the instruction-cache refill controller.
// The optional statistics counters are enabled with ICACHE_REFILL_STATS_EN.
package icache_refill_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } icache_refill_state_e;

  localparam int mem_data_width_lp = 32;

  // Saturating increment used by the statistics counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Miss, memory-read and icache-write signals of the refill controller.
// ICACHE_REFILL_STATS_EN adds the stat_refills / stat_stall_cycles outputs.
interface icache_refill_ctrl_if
  import icache_refill_ctrl_pkg::*;
#(
  parameter int pc_width_p = 12
) ();

  logic                         miss_v;
  logic [pc_width_p-1:0]        miss_pc;
  logic                         busy;
  logic                         mem_req_v;
  logic [pc_width_p-1:0]        mem_req_addr;
  logic                         mem_req_ready;
  logic                         mem_resp_v;
  logic [mem_data_width_lp-1:0] mem_resp_data;
  logic                         mem_resp_yumi;
  logic                         icache_v;
  logic                         icache_w;
  logic [pc_width_p-1:0]        icache_w_pc;
  logic [mem_data_width_lp-1:0] icache_w_instr;
  logic                         icache_flush;
  logic                         refill_done;
`ifdef ICACHE_REFILL_STATS_EN
  logic [31:0]                  stat_refills;
  logic [31:0]                  stat_stall_cycles;

  modport master (
    input  miss_v, miss_pc, mem_req_ready, mem_resp_v, mem_resp_data,
    output busy, mem_req_v, mem_req_addr, mem_resp_yumi,
    output icache_v, icache_w, icache_w_pc, icache_w_instr, icache_flush, refill_done,
    output stat_refills, stat_stall_cycles
  );
  modport slave (
    output miss_v, miss_pc, mem_req_ready, mem_resp_v, mem_resp_data,
    input  busy, mem_req_v, mem_req_addr, mem_resp_yumi,
    input  icache_v, icache_w, icache_w_pc, icache_w_instr, icache_flush, refill_done,
    input  stat_refills, stat_stall_cycles
  );
`else
  modport master (
    input  miss_v, miss_pc, mem_req_ready, mem_resp_v, mem_resp_data,
    output busy, mem_req_v, mem_req_addr, mem_resp_yumi,
    output icache_v, icache_w, icache_w_pc, icache_w_instr, icache_flush, refill_done
  );
  modport slave (
    output miss_v, miss_pc, mem_req_ready, mem_resp_v, mem_resp_data,
    input  busy, mem_req_v, mem_req_addr, mem_resp_yumi,
    input  icache_v, icache_w, icache_w_pc, icache_w_instr, icache_flush, refill_done
  );
`endif

endinterface

// File: rtl/icache_refill_ctrl_credit_counter.sv
// Up/down credit counter bounding in-flight memory reads; reloads to max on init.
module icache_refill_ctrl_credit_counter #(
  parameter int max_p   = 4,
  parameter int width_p = $clog2(max_p + 1)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic init,
  input  logic up,
  input  logic down,
  output logic empty,
  output logic full
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_p);

  logic [width_p-1:0] count_reg;

  // A simultaneous return and issue leaves the count unchanged.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_reg <= max_lp;
    end else if (init) begin
      count_reg <= max_lp;
    end else if (up && !down) begin
      count_reg <= count_reg + 1'b1;
    end else if (down && !up) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign empty = (count_reg == '0);
  assign full  = (count_reg == max_lp);

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache block refill sequencer: issues one read per block word and
// writes responses in offset order. Optional counters under ICACHE_REFILL_STATS_EN.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int icache_tag_width_p           = 6,
  parameter int icache_entries_p             = 64,
  parameter int icache_block_size_in_words_p = 4,
  parameter int max_outstanding_p            = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  icache_refill_ctrl_if.master bus
);

  localparam int pc_width_lp = icache_tag_width_p + $clog2(icache_entries_p);
  localparam int boff_w_lp   = $clog2(icache_block_size_in_words_p);
  localparam int cred_w_lp   = $clog2(max_outstanding_p + 1);

  localparam logic [boff_w_lp:0]     block_words_lp = (boff_w_lp + 1)'(icache_block_size_in_words_p);
  localparam logic [boff_w_lp:0]     last_off_lp    = block_words_lp - 1'b1;
  localparam logic [pc_width_lp-1:0] boff_mask_lp   = pc_width_lp'(icache_block_size_in_words_p - 1);

  icache_refill_state_e   state_reg;
  logic [pc_width_lp-1:0] base_reg;
  logic [boff_w_lp:0]     req_cnt_reg;
  logic [boff_w_lp:0]     resp_cnt_reg;
  logic                   done_pulse_reg;

  logic in_refill;
  logic cred_init;
  logic cred_empty;
  logic cred_full;
  logic req_v;
  logic req_fire;
  logic yumi;
  logic write_last;

  assign in_refill  = (state_reg == REFILL);
  assign cred_init  = (state_reg == IDLE) && bus.miss_v;
  assign req_v      = in_refill && (req_cnt_reg != block_words_lp) && !cred_empty;
  assign req_fire   = req_v && bus.mem_req_ready;
  // A response with nothing outstanding is left unconsumed.
  assign yumi       = in_refill && bus.mem_resp_v && !cred_full;
  assign write_last = yumi && (resp_cnt_reg == last_off_lp);

  icache_refill_ctrl_credit_counter #(
    .max_p   (max_outstanding_p),
    .width_p (cred_w_lp)
  ) credit_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .init      (cred_init),
    .up        (yumi),
    .down      (req_fire),
    .empty     (cred_empty),
    .full      (cred_full)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg      <= IDLE;
      base_reg       <= '0;
      req_cnt_reg    <= '0;
      resp_cnt_reg   <= '0;
      done_pulse_reg <= 1'b0;
    end else begin
      done_pulse_reg <= write_last;
      unique case (state_reg)
        IDLE: begin
          if (bus.miss_v) begin
            base_reg     <= bus.miss_pc & ~boff_mask_lp;
            req_cnt_reg  <= '0;
            resp_cnt_reg <= '0;
            state_reg    <= REFILL;
          end
        end
        REFILL: begin
          if (req_fire) begin
            req_cnt_reg <= req_cnt_reg + 1'b1;
          end
          if (yumi) begin
            resp_cnt_reg <= resp_cnt_reg + 1'b1;
          end
          if (write_last) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy           = (state_reg != IDLE);
  assign bus.mem_req_v      = req_v;
  assign bus.mem_req_addr   = req_v ? (base_reg | pc_width_lp'(req_cnt_reg[boff_w_lp-1:0])) : '0;
  assign bus.mem_resp_yumi  = yumi;
  assign bus.icache_v       = yumi;
  assign bus.icache_w       = yumi;
  assign bus.icache_w_pc    = yumi ? (base_reg | pc_width_lp'(resp_cnt_reg[boff_w_lp-1:0])) : '0;
  assign bus.icache_w_instr = yumi ? bus.mem_resp_data : '0;
  assign bus.icache_flush   = done_pulse_reg;
  assign bus.refill_done    = done_pulse_reg;

`ifdef ICACHE_REFILL_STATS_EN
  logic [31:0] stat_refills_reg;
  logic [31:0] stat_stall_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stat_refills_reg <= '0;
      stat_stall_reg   <= '0;
    end else begin
      if (state_reg == DONE) begin
        stat_refills_reg <= sat_inc32(stat_refills_reg);
      end
      if (state_reg != IDLE) begin
        stat_stall_reg <= sat_inc32(stat_stall_reg);
      end
    end
  end

  assign bus.stat_refills      = stat_refills_reg;
  assign bus.stat_stall_cycles = stat_stall_reg;
`endif

  resp_protocol_a : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      bus.mem_resp_v |-> (in_refill && !cred_full))
    else $error("icache_refill_ctrl: memory response with no read outstanding");

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl (block=4, two reads outstanding) with a
// transaction-level reference model; stats checks need ICACHE_REFILL_STATS_EN.
module tb_icache_refill_ctrl;

  localparam int TAG   = 6;
  localparam int ENT   = 64;
  localparam int BLOCK = 4;
  localparam int MAXO  = 2;
  localparam int PCW   = TAG + $clog2(ENT);

  typedef struct {
    int addr;
    int due;
  } mreq_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  icache_refill_ctrl_if #(.pc_width_p(PCW)) bus ();

  icache_refill_ctrl #(
    .icache_tag_width_p           (TAG),
    .icache_entries_p             (ENT),
    .icache_block_size_in_words_p (BLOCK),
    .max_outstanding_p            (MAXO)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // memory environment and stimulus knobs
  mreq_t mq[$];
  int    lat_min = 1, lat_max = 1;
  bit    rand_ready = 0, ready_fixed = 1, withhold = 0, rand_withhold = 0;

  // logs of what the DUT actually did
  int req_log[$];
  int wr_log[$];
  int wr_cyc[$];
  int done_log[$];
  int busy_cycles = 0;

  // reference model: refill as counts of issued / written / in-flight words
  bit m_active = 0, m_done = 0;
  int m_base = 0, m_issued = 0, m_written = 0, m_inflight = 0;
  int m_stall = 0, m_refills = 0;

  function automatic logic [31:0] mem_word(input int a);
    return 32'h5EED_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    bit exp_req_v, exp_yumi;
    if (!reset_n) begin
      m_active = 0; m_done = 0; m_stall = 0; m_refills = 0; busy_cycles = 0;
      check("rst_busy", 64'(bus.busy), 0);
      check("rst_req_v", 64'(bus.mem_req_v), 0);
      check("rst_icache_v", 64'(bus.icache_v), 0);
      check("rst_done", 64'(bus.refill_done), 0);
    end else begin
      exp_req_v = m_active && (m_issued < BLOCK) && (m_inflight < MAXO);
      exp_yumi  = m_active && bus.mem_resp_v && (m_inflight > 0);
      check("busy", 64'(bus.busy), 64'(m_active || m_done));
      check("req_v", 64'(bus.mem_req_v), 64'(exp_req_v));
      if (exp_req_v) check("req_addr", 64'(bus.mem_req_addr), 64'(m_base + m_issued));
      check("yumi", 64'(bus.mem_resp_yumi), 64'(exp_yumi));
      check("icache_v", 64'(bus.icache_v), 64'(exp_yumi));
      check("icache_w", 64'(bus.icache_w), 64'(exp_yumi));
      if (exp_yumi) begin
        check("w_pc", 64'(bus.icache_w_pc), 64'(m_base + m_written));
        check("w_instr", 64'(bus.icache_w_instr), 64'(mem_word(m_base + m_written)));
      end
      check("flush", 64'(bus.icache_flush), 64'(m_done));
      check("done", 64'(bus.refill_done), 64'(m_done));
`ifdef ICACHE_REFILL_STATS_EN
      check("stat_refills", 64'(bus.stat_refills), 64'(m_refills));
      check("stat_stall", 64'(bus.stat_stall_cycles), 64'(m_stall));
`endif
      // environment bookkeeping from actual DUT activity
      if (bus.mem_req_v && bus.mem_req_ready) begin
        req_log.push_back(int'(bus.mem_req_addr));
        mq.push_back('{addr: int'(bus.mem_req_addr), due: cyc + $urandom_range(lat_min, lat_max)});
      end
      if (bus.mem_resp_v && bus.mem_resp_yumi && mq.size() > 0) void'(mq.pop_front());
      if (bus.icache_v) begin
        wr_log.push_back(int'(bus.icache_w_pc));
        wr_cyc.push_back(cyc);
      end
      if (bus.refill_done) begin
        done_log.push_back(cyc);
        $display("refill done: base=0x%03h cycle=%0d", m_base, cyc);
      end
      if (bus.busy) busy_cycles++;
      // advance the model
      if (m_active || m_done) m_stall++;
      if (m_done) m_refills++;
      if (m_active) begin
        if (exp_req_v && bus.mem_req_ready) begin m_issued++; m_inflight++; end
        if (exp_yumi) begin m_written++; m_inflight--; end
        if (m_written == BLOCK) begin m_active = 0; m_done = 1; end
      end else if (m_done) begin
        m_done = 0;
      end else if (bus.miss_v) begin
        m_active = 1;
        m_base = int'(bus.miss_pc) - (int'(bus.miss_pc) % BLOCK);
        m_issued = 0; m_written = 0; m_inflight = 0;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.mem_req_ready = rand_ready ? ($urandom_range(0, 9) < 7) : ready_fixed;
    if (rand_withhold) withhold = ($urandom_range(0, 4) == 0);
    if (!withhold && mq.size() > 0 && mq[0].due <= cyc) begin
      bus.mem_resp_v    = 1'b1;
      bus.mem_resp_data = mem_word(mq[0].addr);
    end else begin
      bus.mem_resp_v    = 1'b0;
      bus.mem_resp_data = $urandom;
    end
  endtask

  task automatic clear_logs();
    req_log.delete(); wr_log.delete(); wr_cyc.delete(); done_log.delete();
  endtask

  task automatic miss(input int pc);
    bus.miss_v = 1'b1;
    bus.miss_pc = PCW'(pc);
    step();
    bus.miss_v = 1'b0;
  endtask

  task automatic run_until_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_log.size() < target && n < budget) begin
      step();
      n++;
    end
    check(name, 64'(done_log.size()), 64'(target));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.miss_v = 1'b0;
    bus.mem_resp_v = 1'b0;
    mq.delete();
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    int outside;
    bus.miss_v = 1'b0; bus.miss_pc = '0; bus.mem_req_ready = 1'b0;
    bus.mem_resp_v = 1'b0; bus.mem_resp_data = '0;
    step();
    #2;
    check("reset_busy", 64'(bus.busy), 0);
    check("reset_flush", 64'(bus.icache_flush), 0);
    check("reset_addr", 64'(bus.mem_req_addr), 0);
    reset_n = 1'b1;
    step(); step();

    // 1: straight-line refill with one-cycle latency
    clear_logs();
    miss(12'h123);
    run_until_done(1, 60, "t1_timeout");
    for (int i = 0; i < 4; i++) begin
      check("t1_req_addr", 64'(qget(req_log, i)), 64'(12'h120 + i));
      check("t1_wr_pc", 64'(qget(wr_log, i)), 64'(12'h120 + i));
    end
    check("t1_done_after_last_wr", 64'(qget(done_log, 0) - qget(wr_cyc, 3)), 1);
    step(); step();

    // 2: responses withheld -> only two reads issued
    clear_logs();
    withhold = 1;
    miss(12'h123);
    repeat (8) step();
    check("t2_req_count", 64'(req_log.size()), 2);
    check("t2_req0", 64'(qget(req_log, 0)), 64'(12'h120));
    check("t2_req1", 64'(qget(req_log, 1)), 64'(12'h121));
    #2;
    check("t2_req_v_stalled", 64'(bus.mem_req_v), 0);
    withhold = 0;
    run_until_done(1, 60, "t2_timeout");
    check("t2_wr_last", 64'(qget(wr_log, 3)), 64'(12'h123));
    step(); step();

    // 3: ready held low for five cycles
    clear_logs();
    ready_fixed = 0;
    miss(12'h123);
    for (int i = 0; i < 5; i++) begin
      #2;
      check("t3_req_v_held", 64'(bus.mem_req_v), 1);
      check("t3_addr_held", 64'(bus.mem_req_addr), 64'(12'h120));
      step();
    end
    check("t3_no_accept", 64'(req_log.size()), 0);
    ready_fixed = 1;
    run_until_done(1, 60, "t3_timeout");
    step(); step();

    // 4: miss during refill is ignored
    clear_logs();
    lat_min = 1; lat_max = 3;
    miss(12'h123);
    step(); step();
    miss(12'h200);
    run_until_done(1, 100, "t4_timeout");
    outside = 0;
    foreach (wr_log[i]) if ((wr_log[i] & ~3) != 12'h120) outside++;
    check("t4_wr_outside_block", 64'(outside), 0);
    check("t4_wr_count", 64'(wr_log.size()), 4);
    repeat (6) step();
    #2;
    check("t4_idle_busy", 64'(bus.busy), 0);
    check("t4_no_new_refill", 64'(done_log.size() * 8 + req_log.size()), 12);

    // 5: reset after the second write
    clear_logs();
    lat_min = 1; lat_max = 1;
    miss(12'h123);
    for (int n = 0; wr_log.size() < 2 && n < 40; n++) step();
    reset_n = 1'b0;
    bus.mem_resp_v = 1'b0;
    mq.delete();
    #2;
    check("t5_busy", 64'(bus.busy), 0);
    check("t5_req_v", 64'(bus.mem_req_v), 0);
    check("t5_addr", 64'(bus.mem_req_addr), 0);
    check("t5_yumi", 64'(bus.mem_resp_yumi), 0);
    check("t5_icache_v", 64'(bus.icache_v), 0);
    check("t5_icache_w", 64'(bus.icache_w), 0);
    check("t5_w_pc", 64'(bus.icache_w_pc), 0);
    check("t5_w_instr", 64'(bus.icache_w_instr), 0);
    check("t5_flush", 64'(bus.icache_flush), 0);
    check("t5_done", 64'(bus.refill_done), 0);
    step(); step();
    reset_n = 1'b1;
    step();
    clear_logs();
    miss(12'h040);
    run_until_done(1, 60, "t5_timeout");
    check("t5_req0", 64'(qget(req_log, 0)), 64'(12'h040));
    for (int i = 0; i < 4; i++) check("t5_wr_pc", 64'(qget(wr_log, i)), 64'(12'h040 + i));

    // random traffic against the model
    clear_logs();
    rand_ready = 1; rand_withhold = 1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 2500; i++) begin
      bus.miss_v  = ($urandom_range(0, 2) == 0);
      bus.miss_pc = PCW'($urandom_range(0, (1 << PCW) - 1));
      step();
    end
    bus.miss_v = 1'b0;
    rand_withhold = 0; withhold = 0;
    for (int n = 0; bus.busy && n < 200; n++) step();
    check("rand_drained", 64'(bus.busy), 0);
    rand_ready = 0; ready_fixed = 1; lat_min = 1; lat_max = 1;

`ifdef ICACHE_REFILL_STATS_EN
    // 6: three back-to-back refills counted by the statistics outputs
    do_reset();
    clear_logs();
    bus.miss_v = 1'b1;
    bus.miss_pc = PCW'(12'h300);
    run_until_done(3, 100, "t6_timeout");
    bus.miss_v = 1'b0;
    step(); step(); step();
    #2;
    check("t6_refills", 64'(bus.stat_refills), 3);
    check("t6_stall_vs_busy", 64'(bus.stat_stall_cycles), 64'(busy_cycles));
    check("t6_stall_literal", 64'(bus.stat_stall_cycles), 18);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
